prco_reg_dump: RTL and testbench

PRCO_REG_DUMP -- requirements
Module: prco_reg_dump

---
 rtl/prco_reg_dump.sv | 165 ++++++++++++++++
 tb/tb_prco_reg_dump.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prco_reg_dump.sv
// prco_reg_dump: walks a register file and streams its contents as a byte
// frame: HEADER, then {hi, lo} for each register 0..NREGS-1, then an 8-bit
// checksum (modulo-256 sum of the data bytes only, header excluded).
//
// Ports
//   i_clk       single clock, rising edge
//   i_reset     synchronous active-high reset
//   i_start     request one frame (accepted only in IDLE)
//   o_busy      frame in progress (HDR..CSUM)
//   o_done      one-cycle completion pulse
//   o_sel       register-file read select
//   o_rd_ce     register-file pipeline enable (RD only)
//   i_dat       registered register-file data, valid the cycle after RD
//   o_tx_data   byte to the serial transmitter
//   o_tx_valid  o_tx_data valid
//   i_tx_ready  transmitter accepts (transfer = valid & ready on rising edge)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for i_start
// HDR   | offering HEADER byte
// RD    | presenting o_sel/o_rd_ce to the register file for one cycle
// CAP   | register-file data arrives; latched into the word buffer
// HI    | offering word[15:8]
// LO    | offering word[7:0]; then next register or checksum
// CSUM  | offering checksum byte
// DONE  | one-cycle completion pulse

module prco_reg_dump #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         NREGS  = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic [2:0]  o_sel,
  output logic        o_rd_ce,
  input  logic [15:0] i_dat,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_RD, S_CAP, S_HI, S_LO, S_CSUM, S_DONE
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NREGS - 1);

  state_t      state_q;
  logic [2:0]  idx_q;
  logic [7:0]  csum_q;
  logic [15:0] word_q;
  logic        busy_q;
  logic        done_q;
  logic [2:0]  sel_q;
  logic        rd_ce_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;

  logic        xfer;
  logic [7:0]  csum_d;

  assign xfer = tx_valid_q & i_tx_ready;

  // Checksum value after the byte currently on offer is accepted.
  always_comb begin
    csum_d = csum_q;
    if (state_q == S_HI)      csum_d = csum_q + word_q[15:8];
    else if (state_q == S_LO) csum_d = csum_q + word_q[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      csum_q     <= '0;
      word_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sel_q      <= '0;
      rd_ce_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            idx_q      <= '0;
            csum_q     <= '0;
            busy_q     <= 1'b1;
            tx_valid_q <= 1'b1;
            tx_data_q  <= HEADER;
            state_q    <= S_HDR;
          end
        end
        S_HDR: begin
          if (xfer) begin
            tx_valid_q <= 1'b0;
            sel_q      <= idx_q;
            rd_ce_q    <= 1'b1;
            state_q    <= S_RD;
          end
        end
        S_RD: begin
          rd_ce_q <= 1'b0;
          state_q <= S_CAP;
        end
        S_CAP: begin
          // Output byte is loaded straight from i_dat so HI can offer it
          // in its first cycle; the buffer keeps the word for LO and csum.
          word_q     <= i_dat;
          tx_data_q  <= i_dat[15:8];
          tx_valid_q <= 1'b1;
          state_q    <= S_HI;
        end
        S_HI: begin
          if (xfer) begin
            csum_q    <= csum_d;
            tx_data_q <= word_q[7:0];
            state_q   <= S_LO;
          end
        end
        S_LO: begin
          if (xfer) begin
            csum_q <= csum_d;
            if (idx_q == LAST_IDX) begin
              tx_data_q <= csum_d;
              state_q   <= S_CSUM;
            end else begin
              idx_q      <= idx_q + 3'd1;
              sel_q      <= idx_q + 3'd1;
              rd_ce_q    <= 1'b1;
              tx_valid_q <= 1'b0;
              state_q    <= S_RD;
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_sel      = sel_q;
  assign o_rd_ce    = rd_ce_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;

endmodule

// File: tb/tb_prco_reg_dump.sv
// Bench for prco_reg_dump: a registered register-file model feeds i_dat, a
// monitor collects accepted bytes and stall behaviour, and each test compares
// the collected frame with one built directly from the register contents.

module tb_prco_reg_dump;

  logic        clk        = 1'b0;
  logic        i_reset    = 1'b1;
  logic        i_start    = 1'b0;
  logic        i_tx_ready = 1'b0;
  logic [15:0] i_dat      = '0;
  logic        o_busy, o_done, o_rd_ce, o_tx_valid;
  logic [2:0]  o_sel;
  logic [7:0]  o_tx_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] regs [8];
  logic [7:0]  rx_q [$];
  logic [7:0]  exp_q [$];
  int          stall_err = 0;
  int          done_cnt  = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = '0;

  always #5 clk = ~clk;

  prco_reg_dump dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_sel      (o_sel),
    .o_rd_ce    (o_rd_ce),
    .i_dat      (i_dat),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready)
  );

  // Register file with a registered A port.
  always @(posedge clk) if (o_rd_ce === 1'b1) i_dat <= regs[o_sel];

  // Byte collector and stall monitor.
  always @(posedge clk) begin
    if (i_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (o_tx_valid !== 1'b1 || o_tx_data !== prev_data)) stall_err++;
      if (o_tx_valid === 1'b1 && i_tx_ready) rx_q.push_back(o_tx_data);
      if (o_done === 1'b1) done_cnt++;
      prev_stall = (o_tx_valid === 1'b1) && !i_tx_ready;
      prev_data  = o_tx_data;
    end
  end

  // Expected frame straight from the register contents.
  task automatic build_expected();
    int sum = 0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(regs[k][15:8]);
      exp_q.push_back(regs[k][7:0]);
      sum += int'(regs[k][15:8]) + int'(regs[k][7:0]);
    end
    exp_q.push_back(8'(sum));
  endtask

  // Starts a frame at the current negedge and runs until o_done is seen.
  // Returns at the negedge of the cycle after DONE.
  task automatic run_frame(input bit rnd_ready, input bit rnd_start,
                           input bit start_in_done, input int mod_at,
                           output int done_cyc);
    int cyc;
    bit modded = 1'b0;
    rx_q.delete();
    done_cnt  = 0;
    stall_err = 0;
    done_cyc  = -1;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 600) begin
      if (o_done === 1'b1) begin
        done_cyc = cyc;
      end else begin
        if (!modded && mod_at >= 0 && rx_q.size() >= mod_at) begin
          regs[2] = ~regs[2];
          modded  = 1'b1;
        end
        i_tx_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        i_start    = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    i_start = start_in_done;
    @(negedge clk);
    i_start    = 1'b0;
    i_tx_ready = 1'b1;
  endtask

  task automatic load_rk();
    for (int k = 0; k < 8; k++) regs[k] = {4'h0, 4'(k), 4'h0, 4'(k)};
  endtask

  task automatic test_reset();
    @(negedge clk);
    i_reset = 1'b1;
    i_start = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_sel, o_rd_ce, o_tx_data, o_tx_valid} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b sel=%0d rd_ce=%b data=%h valid=%b, required all 0",
               o_busy, o_done, o_sel, o_rd_ce, o_tx_data, o_tx_valid);
    end
    i_reset = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: got busy=%b valid=%b, required 0 0", o_busy, o_tx_valid);
    end
  endtask

  task automatic test_rk_frame();
    int dc;
    load_rk();
    build_expected();
    run_frame(1'b0, 1'b0, 1'b0, -1, dc);
    checks++;
    if (exp_q[17] !== 8'h38) begin
      errors++;
      $display("FAIL rk_model_csum: got %h required 38", exp_q[17]);
    end
    checks++;
    if (dc != 35) begin
      errors++;
      $display("FAIL rk_done_cycle: got %0d required 35", dc);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL rk_done_count: got %0d required 1", done_cnt);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rk_len: got %0d required %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rk_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_all_ff();
    int dc;
    for (int k = 0; k < 8; k++) regs[k] = 16'hFFFF;
    run_frame(1'b0, 1'b0, 1'b0, -1, dc);
    checks++;
    if (rx_q.size() != 18) begin
      errors++;
      $display("FAIL ff_len: got %0d required 18", rx_q.size());
    end else begin
      for (int i = 1; i < 17; i++) begin
        checks++;
        if (rx_q[i] !== 8'hFF) begin
          errors++;
          $display("FAIL ff_byte%0d: got %h required ff", i, rx_q[i]);
        end
      end
      checks++;
      if (rx_q[17] !== 8'hF0) begin
        errors++;
        $display("FAIL ff_csum: got %h required f0", rx_q[17]);
      end
    end
  endtask

  task automatic test_backpressure(input bit random_regs);
    int dc;
    if (random_regs) for (int k = 0; k < 8; k++) regs[k] = 16'($urandom);
    else load_rk();
    build_expected();
    run_frame(1'b1, 1'b0, 1'b0, -1, dc);
    checks++;
    if (stall_err != 0) begin
      errors++;
      $display("FAIL bp_stall_hold: got %0d violations required 0", stall_err);
    end
    checks++;
    if (done_cnt != 1 || dc < 35) begin
      errors++;
      $display("FAIL bp_done: got count=%0d cycle=%0d required count 1 cycle>=35", done_cnt, dc);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_len: got %0d required %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bp_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_start_storm();
    int dc;
    load_rk();
    build_expected();
    run_frame(1'b0, 1'b1, 1'b1, -1, dc);
    checks++;
    if (done_cnt != 1 || rx_q.size() != 18) begin
      errors++;
      $display("FAIL storm_single_frame: got done=%0d bytes=%0d required 1 18", done_cnt, rx_q.size());
    end
    checks++;
    if (o_busy !== 1'b0 || o_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL storm_done_start_ignored: got busy=%b valid=%b required 0 0", o_busy, o_tx_valid);
    end
    // Start in the IDLE cycle right after DONE begins a fresh frame.
    run_frame(1'b0, 1'b0, 1'b0, -1, dc);
    checks++;
    if (dc != 35 || done_cnt != 1) begin
      errors++;
      $display("FAIL storm_next_frame: got cycle=%0d done=%0d required 35 1", dc, done_cnt);
    end
    checks++;
    if (rx_q.size() != 18 || rx_q[0] !== 8'hA5 || rx_q[17] !== 8'h38) begin
      errors++;
      $display("FAIL storm_next_bytes: got len=%0d first/last wrong, required 18 bytes a5..38", rx_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    int cyc = 0;
    int dc;
    load_rk();
    build_expected();
    rx_q.delete();
    done_cnt   = 0;
    i_tx_ready = 1'b1;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    while (rx_q.size() < 9 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (rx_q.size() != 9) begin
      errors++;
      $display("FAIL mid_reach_r3lo: got %0d bytes required 9", rx_q.size());
    end
    i_reset = 1'b1;
    @(negedge clk);
    checks++;
    if (o_tx_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got valid=%b busy=%b required 0 0", o_tx_valid, o_busy);
    end
    i_reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt != 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_done_no_restart: got done=%0d busy=%b required 0 0", done_cnt, o_busy);
    end
    run_frame(1'b0, 1'b0, 1'b0, -1, dc);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL mid_refr_len: got %0d required %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL mid_refr_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_live_update();
    int dc;
    int sum = 0;
    for (int k = 0; k < 8; k++) regs[k] = 16'($urandom);
    build_expected();
    // R2 is changed once its high byte has gone out (its CAP is past).
    run_frame(1'b1, 1'b0, 1'b0, 6, dc);
    checks++;
    if (rx_q.size() != 18) begin
      errors++;
      $display("FAIL live_len: got %0d required 18", rx_q.size());
    end else begin
      for (int i = 0; i < 18; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL live_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]);
        end
      end
      for (int i = 1; i < 17; i++) sum += int'(rx_q[i]);
      checks++;
      if (rx_q[17] !== 8'(sum)) begin
        errors++;
        $display("FAIL live_csum_consistent: got %h required %h", rx_q[17], 8'(sum));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) regs[k] = '0;
    test_reset();
    test_rk_frame();
    test_all_ff();
    test_backpressure(1'b0);
    test_backpressure(1'b1);
    test_start_storm();
    test_reset_midframe();
    test_live_update();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
